// File: rtl/core_pkg.sv
// Shared types and constants for the load/store unit.
// Latency: none (declarations and pure helper functions only).
// Backpressure: not applicable.
package core_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        ACCESS2 = 2'd2,
        RESP    = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2,
        MEM_D = 2'd3
    } mem_size_e;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LD  = 3'd3;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_LWU = 3'd6;

    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;
    localparam logic [2:0] F3_SD  = 3'd3;

    // wide = 1 on a 64-bit datapath, where doubleword and LWU become legal
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3, input logic wide);
        logic ok;
        ok = 1'b0;
        if (is_store) begin
            ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW) || (wide && (f3 == F3_SD));
        end else begin
            case (f3)
                F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
                F3_LD, F3_LWU:                       ok = wide;
                default:                             ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    function automatic logic is_misaligned(input mem_size_e sz, input logic [2:0] ea_lo);
        logic mis;
        case (sz)
            MEM_H:   mis = ea_lo[0];
            MEM_W:   mis = |ea_lo[1:0];
            MEM_D:   mis = |ea_lo[2:0];
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: byte enables and write data shifted up by the lane offset, read data merged, shifted down and extended.
// Latency: purely combinational.
// Backpressure: none; follows its inputs.
module lsu_lane_align
    import core_pkg::*;
#(
    parameter int DATA_WIDTH = 31
) (
    input  logic [2:0]                      off,
    input  mem_size_e                       size,
    input  logic                            sign_ext,
    input  logic [DATA_WIDTH:0]             store_data,
    input  logic [DATA_WIDTH:0]             rdata_lo,
    input  logic [DATA_WIDTH:0]             rdata_hi,
    output logic [(DATA_WIDTH+1)/8-1:0]     be_lo,
    output logic [(DATA_WIDTH+1)/8-1:0]     be_hi,
    output logic [DATA_WIDTH:0]             wdata_lo,
    output logic [DATA_WIDTH:0]             wdata_hi,
    output logic [DATA_WIDTH:0]             load_data
);
    localparam int W  = DATA_WIDTH + 1;
    localparam int NB = W / 8;

    logic [2*NB-1:0] mask;
    logic [2*NB-1:0] be_wide;
    logic [2*W-1:0]  wd_wide;
    logic [W-1:0]    rd_sh;
    logic            sign;
    int              nbits;

    // Two-word-wide shifts so a split access gets its upper lanes in the *_hi halves
    always_comb begin
        mask = '0;
        case (size)
            MEM_B:   mask[0]      = 1'b1;
            MEM_H:   mask[1:0]    = 2'b11;
            MEM_W:   mask[3:0]    = 4'hF;
            default: mask[NB-1:0] = '1;
        endcase
        be_wide  = mask << off;
        be_lo    = be_wide[NB-1:0];
        be_hi    = be_wide[2*NB-1:NB];
        wd_wide  = {{W{1'b0}}, store_data} << {off, 3'b000};
        wdata_lo = wd_wide[W-1:0];
        wdata_hi = wd_wide[2*W-1:W];
    end

    // Merge both beats, bring the addressed bytes down to lane 0, then sign/zero extend
    always_comb begin
        rd_sh = W'({rdata_hi, rdata_lo} >> {off, 3'b000});
        case (size)
            MEM_B:   begin nbits = 8;  sign = rd_sh[7];   end
            MEM_H:   begin nbits = 16; sign = rd_sh[15];  end
            MEM_W:   begin nbits = 32; sign = rd_sh[31];  end
            default: begin nbits = 64; sign = rd_sh[W-1]; end
        endcase
        load_data = '0;
        for (int i = 0; i < W; i++) begin
            load_data[i] = (i < nbits) ? rd_sh[i] : (sign_ext & sign);
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding request, aligned bus accesses; LSU_MISALIGNED_SPLIT_EN splits misaligned accesses in two.
// Latency: accept -> response two cycles with zero wait states; illegal/aborted requests respond the cycle after accept.
// Backpressure: o_req_ready only in IDLE; memory beats held until i_mem_ready; clk_en low freezes everything.
module load_store_unit
    import core_pkg::*;
#(
    parameter int ADDR_WIDTH = 31,
    parameter int DATA_WIDTH = 31
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clk_en,
    input  logic                            i_req_valid,
    input  logic                            i_is_store,
    input  logic [2:0]                      i_funct3,
    input  logic [DATA_WIDTH:0]             i_base,
    input  logic [DATA_WIDTH:0]             i_imm,
    input  logic [DATA_WIDTH:0]             i_store_data,
    input  logic [4:0]                      i_rd,
    output logic                            o_req_ready,
    output logic                            o_mem_req,
    output logic                            o_mem_we,
    output logic [ADDR_WIDTH:0]             o_mem_addr,
    output logic [(DATA_WIDTH+1)/8-1:0]     o_mem_be,
    output logic [DATA_WIDTH:0]             o_mem_wdata,
    input  logic                            i_mem_ready,
    input  logic [DATA_WIDTH:0]             i_mem_rdata,
    output logic                            o_resp_valid,
    output logic [4:0]                      o_resp_rd,
    output logic [DATA_WIDTH:0]             o_resp_data,
    output logic                            o_resp_write_en,
    output logic                            o_misaligned,
    output logic                            o_busy
);
    localparam int   W    = DATA_WIDTH + 1;
    localparam int   NB   = W / 8;
    localparam int   OW   = $clog2(NB);
    localparam int   AW   = ADDR_WIDTH + 1;
    localparam int   XW   = (AW > W) ? AW : W;
    localparam logic WIDE = (DATA_WIDTH == 63);

    lsu_state_e     state_q, state_d;
    logic           is_store_q;
    logic [2:0]     f3_q;
    logic [AW-1:0]  ea_q;
    logic [W-1:0]   sdata_q, rdata_lo_q, rdata_hi_q;
    logic [4:0]     rd_q;

    logic [XW-1:0]  sum;
    logic [AW-1:0]  ea_in, base_addr, addr2;
    logic           in_legal, in_mis, in_abort;
    mem_size_e      size_q;
    logic           legal_q, mis_q, abort_q, need_hi;
    logic [2:0]     off;
    logic [NB-1:0]  be_lo, be_hi;
    logic [W-1:0]   wdata_lo, wdata_hi, load_data;

    assign sum      = XW'(i_base) + XW'(i_imm);
    assign ea_in    = sum[AW-1:0];
    assign in_legal = f3_legal(i_is_store, i_funct3, WIDE);
    assign in_mis   = is_misaligned(mem_size_e'(i_funct3[1:0]), ea_in[2:0]);

    assign size_q    = mem_size_e'(f3_q[1:0]);
    assign legal_q   = f3_legal(is_store_q, f3_q, WIDE);
    assign mis_q     = is_misaligned(size_q, ea_q[2:0]);
    assign base_addr = {ea_q[AW-1:OW], {OW{1'b0}}};
    assign addr2     = base_addr + AW'(NB);

`ifdef LSU_MISALIGNED_SPLIT_EN
    // A second beat is only needed when the shifted lanes spill past the word
    assign in_abort = 1'b0;
    assign abort_q  = 1'b0;
    assign need_hi  = |be_hi;
`else
    assign in_abort = in_mis;
    assign abort_q  = mis_q;
    assign need_hi  = 1'b0;
`endif

    // Zero-extend the lane offset to the 3-bit form the aligner takes
    always_comb begin
        off         = '0;
        off[OW-1:0] = ea_q[OW-1:0];
    end

    lsu_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .off        (off),
        .size       (size_q),
        .sign_ext   (~f3_q[2]),
        .store_data (sdata_q),
        .rdata_lo   (rdata_lo_q),
        .rdata_hi   (rdata_hi_q),
        .be_lo      (be_lo),
        .be_hi      (be_hi),
        .wdata_lo   (wdata_lo),
        .wdata_hi   (wdata_hi),
        .load_data  (load_data)
    );

    // State register; clk_en low freezes the FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      state_q <= IDLE;
        else if (clk_en) state_q <= state_d;
    end

    // Next state: illegal or unsplittable-misaligned requests skip the bus
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_req_valid) state_d = (in_legal && !in_abort) ? ACCESS : RESP;
            ACCESS:  if (i_mem_ready) state_d = need_hi ? ACCESS2 : RESP;
            ACCESS2: if (i_mem_ready) state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    // Capture the request on accept and each read beat on its handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_store_q <= 1'b0;
            f3_q       <= '0;
            ea_q       <= '0;
            sdata_q    <= '0;
            rd_q       <= '0;
            rdata_lo_q <= '0;
            rdata_hi_q <= '0;
        end else if (clk_en) begin
            if (state_q == IDLE && i_req_valid) begin
                is_store_q <= i_is_store;
                f3_q       <= i_funct3;
                ea_q       <= ea_in;
                sdata_q    <= i_store_data;
                rd_q       <= i_rd;
            end
            if (state_q == ACCESS && i_mem_ready)  rdata_lo_q <= i_mem_rdata;
            if (state_q == ACCESS2 && i_mem_ready) rdata_hi_q <= i_mem_rdata;
        end
    end

    // Outputs decoded from state; everything outside its phase reads as zero
    always_comb begin
        o_req_ready     = (state_q == IDLE);
        o_busy          = (state_q != IDLE);
        o_mem_req       = 1'b0;
        o_mem_we        = 1'b0;
        o_mem_addr      = '0;
        o_mem_be        = '0;
        o_mem_wdata     = '0;
        o_resp_valid    = 1'b0;
        o_resp_rd       = '0;
        o_resp_data     = '0;
        o_resp_write_en = 1'b0;
        o_misaligned    = 1'b0;
        case (state_q)
            ACCESS: begin
                o_mem_req   = 1'b1;
                o_mem_we    = is_store_q;
                o_mem_addr  = base_addr;
                o_mem_be    = be_lo;
                o_mem_wdata = wdata_lo;
            end
            ACCESS2: begin
                o_mem_req   = 1'b1;
                o_mem_we    = is_store_q;
                o_mem_addr  = addr2;
                o_mem_be    = be_hi;
                o_mem_wdata = wdata_hi;
            end
            RESP: begin
                o_resp_valid = 1'b1;
                o_resp_rd    = rd_q;
                o_misaligned = legal_q && abort_q;
                if (!is_store_q && legal_q && !abort_q) begin
                    o_resp_data     = load_data;
                    o_resp_write_en = (rd_q != 5'd0);
                end
            end
            default: ;
        endcase
    end

endmodule
